// File: rtl/apb_tx.sv
// APB requester: turns a valid/ready command stream into APB SETUP/ACCESS transfers.
// Optional ACCESS-phase wait timeout enabled by defining APB_TX_TIMEOUT_EN.
module apb_tx #(
  parameter int          DATA_BW     = 8,
  parameter int          ADDR_BW     = 8,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [ADDR_BW-1:0] cmd_addr,
  input  logic [DATA_BW-1:0] cmd_wdata,
  output logic               rsp_valid,
  output logic [DATA_BW-1:0] rsp_rdata,
  output logic               rsp_err,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [ADDR_BW-1:0] paddr,
  output logic [DATA_BW-1:0] pwdata,
  input  logic [DATA_BW-1:0] prdata,
  input  logic               pready,
  input  logic               pslverr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t             state_r, next_state_s;
  logic               psel_r, penable_r, pwrite_r;
  logic [ADDR_BW-1:0] paddr_r;
  logic [DATA_BW-1:0] pwdata_r, rsp_rdata_r;
  logic               rsp_valid_r, rsp_err_r;
  logic               cmd_ready_s, accept_s, complete_s, timeout_s;

  if (TIMEOUT_CYC == 0) begin : g_bad_timeout_cfg
    $error("apb_tx: TIMEOUT_CYC must be at least 1");
  end

`ifdef APB_TX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt_r;

  // ACCESS wait counter: cleared while in SETUP, counts pready-low ACCESS cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= '0;
    end else if (state_r == ST_SETUP) begin
      wait_cnt_r <= '0;
    end else if ((state_r == ST_ACCESS) && !pready) begin
      wait_cnt_r <= wait_cnt_r + 1'b1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  assign timeout_s = (state_r == ST_ACCESS) && !pready &&
                     (wait_cnt_r == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_s = 1'b0;
`endif

  assign complete_s = (state_r == ST_ACCESS) && pready;
  assign accept_s   = cmd_valid && cmd_ready_s && !rst;

  // Ready decode and next-state logic; ready also stays high through reset
  always_comb begin
    cmd_ready_s  = 1'b0;
    next_state_s = state_r;
    if (rst || (state_r == ST_IDLE) || (complete_s && !timeout_s)) begin
      cmd_ready_s = 1'b1;
    end else begin
      cmd_ready_s = 1'b0;
    end
    case (state_r)
      ST_IDLE: begin
        if (accept_s) next_state_s = ST_SETUP;
        else          next_state_s = ST_IDLE;
      end
      ST_SETUP: next_state_s = ST_ACCESS;
      ST_ACCESS: begin
        if (pready) begin
          if (accept_s) next_state_s = ST_SETUP;
          else          next_state_s = ST_IDLE;
        end else if (timeout_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_ACCESS;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State, APB outputs (decoded from next state) and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      psel_r      <= 1'b0;
      penable_r   <= 1'b0;
      pwrite_r    <= 1'b0;
      paddr_r     <= '0;
      pwdata_r    <= '0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= '0;
      rsp_err_r   <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      psel_r      <= (next_state_s == ST_SETUP) || (next_state_s == ST_ACCESS);
      penable_r   <= (next_state_s == ST_ACCESS);
      rsp_valid_r <= complete_s || timeout_s;
      if (accept_s) begin
        pwrite_r <= cmd_write;
        paddr_r  <= cmd_addr;
        pwdata_r <= cmd_wdata;
      end else begin
        pwrite_r <= pwrite_r;
        paddr_r  <= paddr_r;
        pwdata_r <= pwdata_r;
      end
      if (complete_s) begin
        rsp_err_r <= pslverr;
      end else begin
        rsp_err_r <= timeout_s;
      end
      // Write completions and timeouts leave the last read data untouched
      if (complete_s && !pwrite_r) begin
        rsp_rdata_r <= prdata;
      end else begin
        rsp_rdata_r <= rsp_rdata_r;
      end
    end
  end

  assign cmd_ready = cmd_ready_s;
  assign psel      = psel_r;
  assign penable   = penable_r;
  assign pwrite    = pwrite_r;
  assign paddr     = paddr_r;
  assign pwdata    = pwdata_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_apb_tx.sv
// Directed self-checking bench for apb_tx with a response scoreboard.
// Define APB_TX_TIMEOUT_EN for both files to exercise the timeout build.
module tb_apb_tx;

  typedef struct packed {
    logic       err;
    logic [7:0] rdata;
  } rsp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata, prdata;
  logic       pready, pslverr;

  int   checks   = 0;
  int   failures = 0;
  rsp_t exp_q[$];
  logic [7:0] last_rdata;

  apb_tx #(.DATA_BW(8), .ADDR_BW(8), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every response pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL rsp_unexpected observed=1 expected=0");
      end
      if (exp_q.size() != 0) begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_err", rsp_err, e.err);
        chk("rsp_rdata", rsp_rdata, e.rdata);
      end
    end
  end

  task automatic drive_cmd(input logic wr, input logic [7:0] a, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Full single transfer from IDLE with a given number of completer waits
  task automatic xfer(input logic wr, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] rd, input logic err, input int waits);
    rsp_t e;
    step();
    drive_cmd(wr, a, d);
    pready = 1'b0;
    e.err = err;
    e.rdata = wr ? last_rdata : rd;
    last_rdata = e.rdata;
    exp_q.push_back(e);
    step();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("x_setup_psel", psel, 1'b1);
    chk("x_setup_penable", penable, 1'b0);
    chk("x_setup_paddr", paddr, a);
    chk("x_setup_pwrite", pwrite, wr);
    for (int i = 0; i < waits; i++) begin
      step();
      @(negedge clk);
      chk("x_wait_penable", penable, 1'b1);
      chk("x_wait_ready", cmd_ready, 1'b0);
    end
    step();
    pready  = 1'b1;
    pslverr = err;
    prdata  = rd;
    @(negedge clk);
    chk("x_access_penable", penable, 1'b1);
    step();
    pready  = 1'b0;
    pslverr = 1'b0;
    @(negedge clk);
    chk("x_rsp_valid", rsp_valid, 1'b1);
    chk("x_done_psel", psel, 1'b0);
    step();
    @(negedge clk);
    chk("x_rsp_pulse_end", rsp_valid, 1'b0);
  endtask

  initial begin
    rsp_t e;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    prdata = 8'h00; pready = 1'b0; pslverr = 1'b0;
    last_rdata = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_psel", psel, 1'b0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_paddr", paddr, 8'h00);
    chk("rst_pwdata", pwdata, 8'h00);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 8'h00);
    chk("rst_rsp_err", rsp_err, 1'b0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1'b1);

    // Write 0x12/0x5A with zero waits: psel, penable, rsp on cycles 1,2,3
    step();
    drive_cmd(1'b1, 8'h12, 8'h5A);
    pready = 1'b1;
    e.err = 1'b0; e.rdata = last_rdata; exp_q.push_back(e);
    @(negedge clk);
    chk("w_idle_ready", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("w_c1_psel", psel, 1'b1);
    chk("w_c1_penable", penable, 1'b0);
    chk("w_c1_pwrite", pwrite, 1'b1);
    chk("w_c1_paddr", paddr, 8'h12);
    chk("w_c1_pwdata", pwdata, 8'h5A);
    chk("w_c1_ready", cmd_ready, 1'b0);
    step();
    @(negedge clk);
    chk("w_c2_penable", penable, 1'b1);
    chk("w_c2_rsp_valid", rsp_valid, 1'b0);
    chk("w_c2_ready", cmd_ready, 1'b1);
    step();
    pready = 1'b0;
    @(negedge clk);
    chk("w_c3_rsp_valid", rsp_valid, 1'b1);
    chk("w_c3_psel", psel, 1'b0);
    chk("w_c3_pwdata_hold", pwdata, 8'h5A);

    // Read 0x34 with 3 completer waits returning 0xC3
    xfer(1'b0, 8'h34, 8'h00, 8'hC3, 1'b0, 3);
    chk("r_rdata_hold", rsp_rdata, 8'hC3);

    // Back-to-back: write 0x01/0x11 then read 0x02 with no idle cycle
    step();
    drive_cmd(1'b1, 8'h01, 8'h11);
    pready = 1'b1;
    prdata = 8'hA7;
    e.err = 1'b0; e.rdata = last_rdata; exp_q.push_back(e);
    step();
    drive_cmd(1'b0, 8'h02, 8'h00);
    e.err = 1'b0; e.rdata = 8'hA7; exp_q.push_back(e);
    last_rdata = 8'hA7;
    @(negedge clk);
    chk("b2b_s1_paddr", paddr, 8'h01);
    chk("b2b_s1_hold_ready", cmd_ready, 1'b0);
    step();
    @(negedge clk);
    chk("b2b_a1_psel", psel, 1'b1);
    chk("b2b_a1_penable", penable, 1'b1);
    chk("b2b_a1_ready", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("b2b_s2_psel", psel, 1'b1);
    chk("b2b_s2_penable", penable, 1'b0);
    chk("b2b_s2_paddr", paddr, 8'h02);
    chk("b2b_s2_pwrite", pwrite, 1'b0);
    chk("b2b_rsp1", rsp_valid, 1'b1);
    step();
    @(negedge clk);
    chk("b2b_a2_psel", psel, 1'b1);
    chk("b2b_a2_penable", penable, 1'b1);
    chk("b2b_a2_no_rsp", rsp_valid, 1'b0);
    step();
    pready = 1'b0;
    @(negedge clk);
    chk("b2b_rsp2", rsp_valid, 1'b1);
    chk("b2b_done_psel", psel, 1'b0);

    // Slave error on write 0xFF, then a clean read
    xfer(1'b1, 8'hFF, 8'h66, 8'h00, 1'b1, 0);
    xfer(1'b0, 8'h40, 8'h00, 8'h3C, 1'b0, 1);

`ifdef APB_TX_TIMEOUT_EN
    // Timeout after 4 ACCESS cycles with pready held low
    step();
    drive_cmd(1'b0, 8'h66, 8'h00);
    e.err = 1'b1; e.rdata = last_rdata; exp_q.push_back(e);
    step();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("to_setup_psel", psel, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      chk("to_access_penable", penable, 1'b1);
      chk("to_access_ready", cmd_ready, 1'b0);
    end
    step();
    @(negedge clk);
    chk("to_psel_drop", psel, 1'b0);
    chk("to_rsp_valid", rsp_valid, 1'b1);
    chk("to_rsp_err", rsp_err, 1'b1);
`else
    // Without timeout, ACCESS persists while pready stays low
    step();
    drive_cmd(1'b0, 8'h66, 8'h00);
    e.err = 1'b0; e.rdata = 8'h99; exp_q.push_back(e);
    last_rdata = 8'h99;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      @(negedge clk);
      chk("nt_access_penable", penable, 1'b1);
      chk("nt_access_psel", psel, 1'b1);
    end
    step();
    pready = 1'b1;
    prdata = 8'h99;
    step();
    pready = 1'b0;
    @(negedge clk);
    chk("nt_rsp_valid", rsp_valid, 1'b1);
`endif

    // Reset mid-ACCESS aborts the transfer without a response
    step();
    drive_cmd(1'b0, 8'h55, 8'h00);
    step();
    cmd_valid = 1'b0;
    step();
    @(negedge clk);
    chk("ab_access_penable", penable, 1'b1);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("ab_rst_ready", cmd_ready, 1'b1);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("ab_psel", psel, 1'b0);
    chk("ab_penable", penable, 1'b0);
    chk("ab_rsp_valid", rsp_valid, 1'b0);
    chk("ab_cmd_ready", cmd_ready, 1'b1);
    chk("ab_rsp_rdata", rsp_rdata, 8'h00);
    repeat (3) step();
    @(negedge clk);
    chk("ab_still_idle", psel, 1'b0);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_tx.md
APB_TX -- requirements
Module: apb_tx

Interface
REQ-001 Parameter DATA_BW, default 8, width of the pwdata, prdata, cmd_wdata and rsp_rdata buses.
REQ-002 Parameter ADDR_BW, default 8, width of the paddr and cmd_addr buses.
REQ-003 Parameter TIMEOUT_CYC, default 16, number of ACCESS-phase cycles with pready low before abort (used only with APB_TX_TIMEOUT_EN).
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 Port cmd_valid, input, 1 bit: a command is offered.
REQ-007 Port cmd_ready, output, 1 bit: the block accepts the offered command this cycle.
REQ-008 Port cmd_write, input, 1 bit: 1 = write, 0 = read.
REQ-009 Port cmd_addr, input, ADDR_BW bits: command address.
REQ-010 Port cmd_wdata, input, DATA_BW bits: write data.
REQ-011 Port rsp_valid, output, 1 bit: single-cycle pulse marking transfer completion.
REQ-012 Port rsp_rdata, output, DATA_BW bits: read data captured at completion.
REQ-013 Port rsp_err, output, 1 bit: the completed transfer returned an error.
REQ-014 Ports psel, penable, pwrite (outputs, 1 bit), paddr (output, ADDR_BW), pwdata (output, DATA_BW): APB requester signals.
REQ-015 Ports prdata (input, DATA_BW), pready (input, 1 bit), pslverr (input, 1 bit): APB completer signals.

Function
REQ-016 The FSM SHALL have the states IDLE, SETUP and ACCESS, and the state SHALL be registered.
REQ-017 cmd_ready SHALL be 1 in IDLE, 1 in ACCESS when pready=1, and 0 otherwise.
REQ-018 When cmd_valid&&cmd_ready, cmd_write, cmd_addr and cmd_wdata SHALL be captured, and the next state SHALL be SETUP.
REQ-019 In SETUP: psel=1, penable=0, and pwrite, paddr and pwdata SHALL come from the captured registers; the next state SHALL be ACCESS unconditionally.
REQ-020 In ACCESS: psel=1, penable=1, and paddr, pwrite and pwdata SHALL be held stable until completion.
REQ-021 In ACCESS with pready=1 (completion): the next state SHALL be SETUP if a new command is accepted in the same cycle, otherwise IDLE, so back-to-back transfers carry no idle cycle.
REQ-022 In ACCESS with pready=0, the FSM SHALL remain in ACCESS.
REQ-023 At completion, rsp_valid SHALL pulse high for exactly one cycle, on the cycle after the completion edge.
REQ-024 rsp_rdata SHALL equal the prdata sampled at completion for reads and SHALL hold its previous value for writes.
REQ-025 rsp_err SHALL equal the pslverr sampled at completion and SHALL be valid only while rsp_valid=1.
REQ-026 In IDLE, psel and penable SHALL be 0, and paddr, pwrite and pwdata SHALL hold their last values.
REQ-027 A command transfer costs a minimum of 2 cycles (SETUP plus one ACCESS cycle), plus one cycle per pready=0 wait.
REQ-028 rsp_valid has no backpressure; the consumer SHALL sample it on the pulse.
REQ-029 cmd_valid while cmd_ready=0 SHALL NOT be captured, and the requester SHALL hold the command stable until the handshake completes.

Reset
REQ-030 When rst=1 at a rising clk edge, the state SHALL become IDLE and psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata and rsp_err SHALL become 0.
REQ-031 cmd_ready SHALL be 1 during reset and on the cycle after reset.
REQ-032 Reset asserted in SETUP or ACCESS SHALL abort the transfer with no rsp_valid pulse.

Configuration
REQ-033 Macro APB_TX_TIMEOUT_EN, when defined, SHALL add a wait counter that clears on entry to ACCESS and increments on each ACCESS cycle with pready=0.
REQ-034 With APB_TX_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYC the FSM SHALL go to IDLE, pulse rsp_valid with rsp_err=1, and leave rsp_rdata unchanged.
REQ-035 With APB_TX_TIMEOUT_EN defined, a command SHALL NOT be accepted on the timeout cycle.
REQ-036 Without APB_TX_TIMEOUT_EN, the counter SHALL be absent and the FSM SHALL wait in ACCESS indefinitely.

Verification
REQ-037 Write A=0x12, D=0x5A, pready=1: psel on cycle 1, penable on cycle 2; pwrite=1, paddr=0x12, pwdata=0x5A; rsp_valid on cycle 3 with rsp_err=0.
REQ-038 Read A=0x34, completer waits 3 cycles, then prdata=0xC3 with pready=1: exactly 3 wait cycles with penable=1; rsp_rdata=0xC3.
REQ-039 Two commands held back-to-back (write 0x01/0x11, then read 0x02): the second SETUP immediately follows the first ACCESS, psel never drops, and two rsp_valid pulses occur.
REQ-040 pslverr=1 at completion of a write to 0xFF: rsp_err=1 with rsp_valid; a following transfer reports rsp_err=0.
REQ-041 rst=1 asserted mid-ACCESS with pready=0: the next cycle shows psel=0, penable=0, state IDLE, no rsp_valid, and cmd_ready=1.
REQ-042 APB_TX_TIMEOUT_EN with TIMEOUT_CYC=4 and pready held 0: after 4 ACCESS cycles, psel drops and rsp_valid=1 with rsp_err=1.
